// File: rtl/syzygy_adc_clk_supervisor.sv
// Per-channel MMCM supervisor: sequences MMCM reset, waits for lock with timeout
// and bounded retries, qualifies lock as stable, and counts lock losses.
module syzygy_adc_clk_supervisor #(
    parameter int NUM_CH              = 1,
    parameter int RESET_CYCLES        = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       mmcm_locked,
    input  logic [NUM_CH-1:0]       restart,
    output logic [NUM_CH-1:0]       mmcm_reset,
    output logic [NUM_CH-1:0]       clk_ready,
    output logic [NUM_CH-1:0]       fault,
    output logic [NUM_CH*CNT_W-1:0] loss_count
);

    localparam int CYC_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ? RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int CYC_MAX   = (CYC_MAX_A > LOCK_STABLE_CYCLES) ? CYC_MAX_A : LOCK_STABLE_CYCLES;
    localparam int CYC_W     = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int RTY_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RESET_CYCLES - 1);
    localparam logic [CYC_W-1:0] TO_LAST  = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CYC_W-1:0] STB_LAST = CYC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_READY,
        ST_FAULT
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Stage boundary: two-flop synchroniser for the asynchronous LOCKED inputs
    logic [NUM_CH-1:0] locked_p0;
    logic [NUM_CH-1:0] locked_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked_p0 <= '0;
            locked_p1 <= '0;
        end else begin
            locked_p0 <= mmcm_locked;
            locked_p1 <= locked_p0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state, state_nxt;
        logic [CYC_W-1:0] cnt, cnt_nxt;
        logic [RTY_W-1:0] retries, retries_nxt;
        logic [CNT_W-1:0] loss, loss_nxt;
        logic             locked_s;

        assign locked_s = locked_p1[i];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state   <= ST_RST;
                cnt     <= '0;
                retries <= '0;
                loss    <= '0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                retries <= retries_nxt;
                loss    <= loss_nxt;
            end
        end

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            retries_nxt = retries;
            loss_nxt    = loss;
            // Restart outranks everything, including a coincident lock loss
            if (restart[i]) begin
                state_nxt   = ST_RST;
                cnt_nxt     = '0;
                retries_nxt = '0;
            end else begin
                case (state)
                    ST_RST: begin
                        if (cnt == RST_LAST) begin
                            state_nxt = ST_WAIT_LOCK;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CYC_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (locked_s) begin
                            state_nxt = ST_STABLE;
                            cnt_nxt   = '0;
                        end else if (cnt == TO_LAST) begin
                            cnt_nxt = '0;
                            if (retries == RTY_MAX) begin
                                state_nxt = ST_FAULT;
                            end else begin
                                state_nxt   = ST_RST;
                                retries_nxt = retries + RTY_W'(1);
                            end
                        end else begin
                            cnt_nxt = cnt + CYC_W'(1);
                        end
                    end
                    ST_STABLE: begin
                        if (!locked_s) begin
                            state_nxt = ST_WAIT_LOCK;
                            cnt_nxt   = '0;
                        end else if (cnt == STB_LAST) begin
                            state_nxt   = ST_READY;
                            cnt_nxt     = '0;
                            retries_nxt = '0;
                        end else begin
                            cnt_nxt = cnt + CYC_W'(1);
                        end
                    end
                    ST_READY: begin
                        if (!locked_s) begin
                            state_nxt   = ST_RST;
                            cnt_nxt     = '0;
                            retries_nxt = '0;
                            loss_nxt    = sat_inc(loss);
                        end
                    end
                    ST_FAULT: begin
                        state_nxt = ST_FAULT;
                    end
                    default: begin
                        state_nxt   = ST_RST;
                        cnt_nxt     = '0;
                        retries_nxt = '0;
                    end
                endcase
            end
        end

        assign mmcm_reset[i]                   = (state == ST_RST) || (state == ST_FAULT);
        assign clk_ready[i]                    = (state == ST_READY);
        assign fault[i]                        = (state == ST_FAULT);
        assign loss_count[i*CNT_W +: CNT_W]    = loss;
    end

endmodule

// File: tb/tb_syzygy_adc_clk_supervisor.sv
// Directed bench for syzygy_adc_clk_supervisor: bring-up, glitch, timeout/fault,
// lock loss, saturation, restart priority and asynchronous reset.
module tb_syzygy_adc_clk_supervisor;

    localparam int NUM_CH              = 2;
    localparam int RESET_CYCLES        = 4;
    localparam int LOCK_TIMEOUT_CYCLES = 32;
    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int MAX_RETRIES         = 2;
    localparam int CNT_W               = 8;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       mmcm_locked;
    logic [NUM_CH-1:0]       restart;
    logic [NUM_CH-1:0]       mmcm_reset;
    logic [NUM_CH-1:0]       clk_ready;
    logic [NUM_CH-1:0]       fault;
    logic [NUM_CH*CNT_W-1:0] loss_count;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    syzygy_adc_clk_supervisor #(
        .NUM_CH              (NUM_CH),
        .RESET_CYCLES        (RESET_CYCLES),
        .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
        .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
        .MAX_RETRIES         (MAX_RETRIES),
        .CNT_W               (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mmcm_locked (mmcm_locked),
        .restart     (restart),
        .mmcm_reset  (mmcm_reset),
        .clk_ready   (clk_ready),
        .fault       (fault),
        .loss_count  (loss_count)
    );

    // Edge n is the n-th rising edge after reset release; sampling and driving happen 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic step_to(input int e);
        while (edge_n < e) step();
    endtask

    task automatic apply_reset();
        reset_n     = 1'b0;
        mmcm_locked = '0;
        restart     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        edge_n  = 0;
    endtask

    task automatic wait_ready(input int limit, output bit ok);
        int n;
        n = 0;
        while (clk_ready[0] !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        ok = (clk_ready[0] === 1'b1);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        mmcm_locked = 2'b11;
        restart     = '0;
        @(posedge clk);
        #1;
        checks++;
        if (mmcm_reset !== 2'b11) begin
            errors++;
            $display("FAIL reset_mmcm_reset got %b want 11", mmcm_reset);
        end
        checks++;
        if (clk_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_clk_ready got %b want 00", clk_ready);
        end
        checks++;
        if (fault !== 2'b00) begin
            errors++;
            $display("FAIL reset_fault got %b want 00", fault);
        end
        checks++;
        if (loss_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_loss_count got %h want 0000", loss_count);
        end
    endtask

    task automatic test_bringup();
        apply_reset();
        step_to(3);
        checks++;
        if (mmcm_reset !== 2'b11) begin
            errors++;
            $display("FAIL bringup_rst_held_e3 got %b want 11", mmcm_reset);
        end
        step_to(4);
        checks++;
        if (mmcm_reset !== 2'b00) begin
            errors++;
            $display("FAIL bringup_rst_fall_e4 got %b want 00", mmcm_reset);
        end
        step_to(10);
        mmcm_locked[0] = 1'b1;
        step_to(20);
        checks++;
        if (clk_ready !== 2'b00) begin
            errors++;
            $display("FAIL bringup_ready_e20 got %b want 00", clk_ready);
        end
        step_to(21);
        checks++;
        if (clk_ready !== 2'b01) begin
            errors++;
            $display("FAIL bringup_ready_e21 got %b want 01", clk_ready);
        end
        checks++;
        if (mmcm_reset !== 2'b00 || fault !== 2'b00) begin
            errors++;
            $display("FAIL bringup_ch1_idle got rst=%b fault=%b want rst=00 fault=00", mmcm_reset, fault);
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        step_to(10);
        mmcm_locked[0] = 1'b1;
        step_to(14);
        mmcm_locked[0] = 1'b0;
        for (int e = 15; e <= 27; e++) begin
            step_to(e);
            checks++;
            if (clk_ready[0] !== 1'b0 || mmcm_reset[0] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_hold_e%0d got ready=%b rst=%b want ready=0 rst=0", e, clk_ready[0], mmcm_reset[0]);
            end
            if (e == 17) mmcm_locked[0] = 1'b1;
        end
        step_to(28);
        checks++;
        if (clk_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_ready_e28 got %b want 1", clk_ready[0]);
        end
        checks++;
        if (loss_count[7:0] !== 8'd0) begin
            errors++;
            $display("FAIL glitch_loss got %0d want 0", loss_count[7:0]);
        end
    endtask

    task automatic test_loss();
        step_to(30);
        mmcm_locked[0] = 1'b0;
        step_to(32);
        checks++;
        if (clk_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL loss_ready_e32 got %b want 1", clk_ready[0]);
        end
        step_to(33);
        checks++;
        if (clk_ready[0] !== 1'b0 || mmcm_reset[0] !== 1'b1) begin
            errors++;
            $display("FAIL loss_resp_e33 got ready=%b rst=%b want ready=0 rst=1", clk_ready[0], mmcm_reset[0]);
        end
        checks++;
        if (loss_count[7:0] !== 8'd1) begin
            errors++;
            $display("FAIL loss_count_e33 got %0d want 1", loss_count[7:0]);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        mmcm_locked[0] = 1'b1;
        wait_ready(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL simul_reach_ready got 0 want 1");
        end
        mmcm_locked[0] = 1'b0;
        step();
        step();
        restart[0] = 1'b1;
        step();
        restart[0] = 1'b0;
        checks++;
        if (mmcm_reset[0] !== 1'b1 || clk_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL simul_to_rst got rst=%b ready=%b want rst=1 ready=0", mmcm_reset[0], clk_ready[0]);
        end
        checks++;
        if (loss_count[7:0] !== 8'd1) begin
            errors++;
            $display("FAIL simul_loss got %0d want 1", loss_count[7:0]);
        end
        step();
        checks++;
        if (loss_count[7:0] !== 8'd1 || mmcm_reset[0] !== 1'b1) begin
            errors++;
            $display("FAIL simul_after got loss=%0d rst=%b want loss=1 rst=1", loss_count[7:0], mmcm_reset[0]);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        for (int i = 0; i < 300; i++) begin
            mmcm_locked[0] = 1'b1;
            wait_ready(60, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL sat_ready_iter%0d got 0 want 1", i);
                break;
            end
            mmcm_locked[0] = 1'b0;
            repeat (3) step();
            if (i == 0) begin
                checks++;
                if (loss_count[7:0] !== 8'd2) begin
                    errors++;
                    $display("FAIL sat_first_inc got %0d want 2", loss_count[7:0]);
                end
            end
        end
        checks++;
        if (loss_count[7:0] !== 8'd255) begin
            errors++;
            $display("FAIL sat_final got %0d want 255", loss_count[7:0]);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        mmcm_locked[0] = 1'b1;
        wait_ready(60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL async_reach_ready got 0 want 1");
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mmcm_reset !== 2'b11 || clk_ready !== 2'b00 || fault !== 2'b00) begin
            errors++;
            $display("FAIL async_outputs got rst=%b ready=%b fault=%b want rst=11 ready=00 fault=00", mmcm_reset, clk_ready, fault);
        end
        checks++;
        if (loss_count !== 16'h0000) begin
            errors++;
            $display("FAIL async_loss got %h want 0000", loss_count);
        end
    endtask

    task automatic test_no_lock_ch1();
        bit exp_rst;
        bit exp_fault;
        apply_reset();
        for (int e = 1; e <= 119; e++) begin
            step_to(e);
            exp_rst   = (e < 4) || (e >= 36 && e < 40) || (e >= 72 && e < 76) || (e >= 108);
            exp_fault = (e >= 108);
            checks++;
            if (mmcm_reset[1] !== exp_rst || fault[1] !== exp_fault) begin
                errors++;
                $display("FAIL nolock_e%0d got rst=%b fault=%b want rst=%b fault=%b", e, mmcm_reset[1], fault[1], exp_rst, exp_fault);
            end
        end
        restart[1] = 1'b1;
        step_to(120);
        restart[1] = 1'b0;
        checks++;
        if (fault[1] !== 1'b0 || mmcm_reset[1] !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear got fault=%b rst=%b want fault=0 rst=1", fault[1], mmcm_reset[1]);
        end
        checks++;
        if (fault[0] !== 1'b1) begin
            errors++;
            $display("FAIL restart_ch0_kept got %b want 1", fault[0]);
        end
        step_to(123);
        checks++;
        if (mmcm_reset[1] !== 1'b1) begin
            errors++;
            $display("FAIL restart_pulse_e123 got %b want 1", mmcm_reset[1]);
        end
        step_to(124);
        checks++;
        if (mmcm_reset[1] !== 1'b0) begin
            errors++;
            $display("FAIL restart_pulse_end_e124 got %b want 0", mmcm_reset[1]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bringup();
        test_glitch();
        test_loss();
        test_simultaneous();
        test_saturate();
        test_async_reset();
        test_no_lock_ch1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
